// File: rtl/control_status_regfile_16_if.sv
// Xillybus-side signal bundle for the 16-bit control/status register files.
// The host side is the master; the register file is the slave.
interface control_status_regfile_16_if;
    logic        user_w_control_regs_16_wren;
    logic [15:0] user_w_control_regs_16_data;
    logic        user_w_control_regs_16_full;
    logic        user_w_control_regs_16_open;
    logic        user_r_control_regs_16_rden;
    logic [15:0] user_r_control_regs_16_data;
    logic        user_r_control_regs_16_empty;
    logic        user_r_control_regs_16_eof;
    logic        user_r_control_regs_16_open;
    logic [4:0]  user_control_regs_16_addr;
    logic        user_control_regs_16_addr_update;
    logic        user_r_status_regs_16_rden;
    logic [15:0] user_r_status_regs_16_data;
    logic        user_r_status_regs_16_empty;
    logic        user_r_status_regs_16_eof;
    logic        user_r_status_regs_16_open;
    logic [4:0]  user_status_regs_16_addr;
    logic        user_status_regs_16_addr_update;

    modport master (
        output user_w_control_regs_16_wren, user_w_control_regs_16_data,
               user_w_control_regs_16_open, user_r_control_regs_16_rden,
               user_r_control_regs_16_open, user_control_regs_16_addr,
               user_control_regs_16_addr_update, user_r_status_regs_16_rden,
               user_r_status_regs_16_open, user_status_regs_16_addr,
               user_status_regs_16_addr_update,
        input  user_w_control_regs_16_full, user_r_control_regs_16_data,
               user_r_control_regs_16_empty, user_r_control_regs_16_eof,
               user_r_status_regs_16_data, user_r_status_regs_16_empty,
               user_r_status_regs_16_eof
    );

    modport slave (
        input  user_w_control_regs_16_wren, user_w_control_regs_16_data,
               user_w_control_regs_16_open, user_r_control_regs_16_rden,
               user_r_control_regs_16_open, user_control_regs_16_addr,
               user_control_regs_16_addr_update, user_r_status_regs_16_rden,
               user_r_status_regs_16_open, user_status_regs_16_addr,
               user_status_regs_16_addr_update,
        output user_w_control_regs_16_full, user_r_control_regs_16_data,
               user_r_control_regs_16_empty, user_r_control_regs_16_eof,
               user_r_status_regs_16_data, user_r_status_regs_16_empty,
               user_r_status_regs_16_eof
    );
endinterface

// File: rtl/control_status_regfile_16.sv
// 32 x 16-bit host-writable control registers plus a 32-word status readback
// window, both addressed by seekable auto-incrementing pointers.
module control_status_regfile_16 #(
    parameter logic [511:0] CTRL_RESET      = 512'd0,
    parameter logic [31:0]  SELF_CLEAR_MASK = 32'd0
) (
    input  logic                              bus_clk,
    input  logic                              reset,
    control_status_regfile_16_if.slave        bus,
    output logic [511:0]                      ctrl_regs,
    output logic [31:0]                       ctrl_wr_pulse,
    input  logic [511:0]                      status_in
);
    localparam logic [31:0][15:0] RESET_WORDS = CTRL_RESET;

    logic [31:0][15:0] regs;
    logic [31:0][15:0] status_words;
    logic [4:0]        cptr;
    logic [4:0]        sptr;
    logic              c_upd_d;
    logic              s_upd_d;
    logic              c_empty;
    logic              s_empty;
    logic              w_acc;
    logic              cr_acc;
    logic              sr_acc;
    logic [15:0]       c_rdata;
    logic [15:0]       s_rdata;

    assign status_words = status_in;

    // Reads stall for the seek cycle and the one after, giving the new pointer time to settle.
    assign c_empty = ~reset & (bus.user_control_regs_16_addr_update | c_upd_d);
    assign s_empty = ~reset & (bus.user_status_regs_16_addr_update | s_upd_d);

    assign w_acc  = bus.user_w_control_regs_16_wren & bus.user_w_control_regs_16_open;
    assign cr_acc = bus.user_r_control_regs_16_rden & bus.user_r_control_regs_16_open & ~c_empty;
    assign sr_acc = bus.user_r_status_regs_16_rden & bus.user_r_status_regs_16_open & ~s_empty;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            cptr    <= 5'd0;
            c_upd_d <= 1'b0;
        end else begin
            c_upd_d <= bus.user_control_regs_16_addr_update;
            if (bus.user_control_regs_16_addr_update)
                cptr <= bus.user_control_regs_16_addr;
            else if (w_acc || cr_acc)
                cptr <= cptr + 5'd1;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            sptr    <= 5'd0;
            s_upd_d <= 1'b0;
        end else begin
            s_upd_d <= bus.user_status_regs_16_addr_update;
            if (bus.user_status_regs_16_addr_update)
                sptr <= bus.user_status_regs_16_addr;
            else if (sr_acc)
                sptr <= sptr + 5'd1;
        end
    end

    // A pending pulse marks last cycle's write; self-clearing registers revert then
    // unless a fresh write lands in the same cycle.
    always_ff @(posedge bus_clk) begin
        if (reset) begin
            regs          <= RESET_WORDS;
            ctrl_wr_pulse <= 32'd0;
        end else begin
            for (int n = 0; n < 32; n++) begin
                if (SELF_CLEAR_MASK[n] && ctrl_wr_pulse[n])
                    regs[n] <= RESET_WORDS[n];
            end
            if (w_acc)
                regs[cptr] <= bus.user_w_control_regs_16_data;
            ctrl_wr_pulse <= w_acc ? (32'd1 << cptr) : 32'd0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            c_rdata <= 16'd0;
            s_rdata <= 16'd0;
        end else begin
            if (cr_acc)
                c_rdata <= regs[cptr];
            if (sr_acc)
                s_rdata <= status_words[sptr];
        end
    end

    assign ctrl_regs = regs;

    assign bus.user_w_control_regs_16_full  = 1'b0;
    assign bus.user_r_control_regs_16_data  = c_rdata;
    assign bus.user_r_control_regs_16_empty = c_empty;
    assign bus.user_r_control_regs_16_eof   = 1'b0;
    assign bus.user_r_status_regs_16_data   = s_rdata;
    assign bus.user_r_status_regs_16_empty  = s_empty;
    assign bus.user_r_status_regs_16_eof    = 1'b0;
endmodule

// File: tb/tb_control_status_regfile_16.sv
// Directed bench for control_status_regfile_16: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_control_status_regfile_16;
    localparam logic [511:0] TB_RESET = (512'h0C0C << (16 * 7))
                                      | (512'h2222 << (16 * 2))
                                      | (512'h5555 << (16 * 6));

    logic              bus_clk = 1'b0;
    logic              reset;
    logic [31:0][15:0] ctrl_regs;
    logic [31:0]       ctrl_wr_pulse;
    logic [31:0][15:0] status_in;
    int                total = 0;
    int                bad   = 0;

    control_status_regfile_16_if bus ();

    control_status_regfile_16 #(
        .CTRL_RESET      (TB_RESET),
        .SELF_CLEAR_MASK (32'h0000_0080)
    ) dut (
        .bus_clk       (bus_clk),
        .reset         (reset),
        .bus           (bus),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .status_in     (status_in)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic idle();
        bus.user_w_control_regs_16_wren      = 1'b0;
        bus.user_w_control_regs_16_data      = 16'd0;
        bus.user_r_control_regs_16_rden      = 1'b0;
        bus.user_control_regs_16_addr        = 5'd0;
        bus.user_control_regs_16_addr_update = 1'b0;
        bus.user_r_status_regs_16_rden       = 1'b0;
        bus.user_status_regs_16_addr         = 5'd0;
        bus.user_status_regs_16_addr_update  = 1'b0;
    endtask

    task automatic seek_ctrl(input logic [4:0] a);
        bus.user_control_regs_16_addr        = a;
        bus.user_control_regs_16_addr_update = 1'b1;
        @(negedge bus_clk);
        bus.user_control_regs_16_addr_update = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] d);
        bus.user_w_control_regs_16_wren = 1'b1;
        bus.user_w_control_regs_16_data = d;
        @(negedge bus_clk);
        bus.user_w_control_regs_16_wren = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        @(negedge bus_clk);
        @(negedge bus_clk);
        total++; if (ctrl_regs !== TB_RESET) begin bad++; $display("[TB] FAIL reset_regs got=%h exp=%h", ctrl_regs, TB_RESET); end
        total++; if (ctrl_wr_pulse !== 32'd0) begin bad++; $display("[TB] FAIL reset_pulse got=%h exp=0", ctrl_wr_pulse); end
        total++; if (bus.user_r_control_regs_16_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.user_r_control_regs_16_data); end
        total++; if (bus.user_r_status_regs_16_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_sdata got=%h exp=0", bus.user_r_status_regs_16_data); end
        total++; if ({bus.user_r_control_regs_16_empty, bus.user_r_status_regs_16_empty} !== 2'b00) begin bad++; $display("[TB] FAIL reset_empty got=%b%b exp=00", bus.user_r_control_regs_16_empty, bus.user_r_status_regs_16_empty); end
        total++; if ({bus.user_w_control_regs_16_full, bus.user_r_control_regs_16_eof, bus.user_r_status_regs_16_eof} !== 3'b000) begin bad++; $display("[TB] FAIL const_flags got=%b%b%b exp=000", bus.user_w_control_regs_16_full, bus.user_r_control_regs_16_eof, bus.user_r_status_regs_16_eof); end
        reset = 1'b0;
        @(negedge bus_clk);
    endtask

    task automatic test_write_seq();
        seek_ctrl(5'd3);
        write_word(16'hA5A5);
        total++; if (ctrl_regs[3] !== 16'hA5A5) begin bad++; $display("[TB] FAIL seq_reg3 got=%h exp=a5a5", ctrl_regs[3]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0008) begin bad++; $display("[TB] FAIL seq_pulse3 got=%h exp=00000008", ctrl_wr_pulse); end
        write_word(16'h1234);
        total++; if (ctrl_regs[4] !== 16'h1234) begin bad++; $display("[TB] FAIL seq_reg4 got=%h exp=1234", ctrl_regs[4]); end
        total++; if (ctrl_regs[3] !== 16'hA5A5) begin bad++; $display("[TB] FAIL seq_reg3_keep got=%h exp=a5a5", ctrl_regs[3]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0010) begin bad++; $display("[TB] FAIL seq_pulse4 got=%h exp=00000010", ctrl_wr_pulse); end
        @(negedge bus_clk);
        total++; if (ctrl_wr_pulse !== 32'd0) begin bad++; $display("[TB] FAIL seq_pulse_end got=%h exp=0", ctrl_wr_pulse); end
    endtask

    task automatic test_wrap();
        seek_ctrl(5'd31);
        write_word(16'h0001);
        total++; if (ctrl_regs[31] !== 16'h0001) begin bad++; $display("[TB] FAIL wrap_reg31 got=%h exp=0001", ctrl_regs[31]); end
        total++; if (ctrl_wr_pulse !== 32'h8000_0000) begin bad++; $display("[TB] FAIL wrap_pulse31 got=%h exp=80000000", ctrl_wr_pulse); end
        write_word(16'h0002);
        total++; if (ctrl_regs[0] !== 16'h0002) begin bad++; $display("[TB] FAIL wrap_reg0 got=%h exp=0002", ctrl_regs[0]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0001) begin bad++; $display("[TB] FAIL wrap_pulse0 got=%h exp=00000001", ctrl_wr_pulse); end
        // Seek coinciding with a write: the write goes to the old pointer (1).
        bus.user_control_regs_16_addr        = 5'd20;
        bus.user_control_regs_16_addr_update = 1'b1;
        bus.user_w_control_regs_16_wren      = 1'b1;
        bus.user_w_control_regs_16_data      = 16'h0BAD;
        @(negedge bus_clk);
        bus.user_control_regs_16_addr_update = 1'b0;
        bus.user_w_control_regs_16_wren      = 1'b0;
        total++; if (ctrl_regs[1] !== 16'h0BAD) begin bad++; $display("[TB] FAIL seekwr_reg1 got=%h exp=0bad", ctrl_regs[1]); end
        total++; if (ctrl_regs[20] !== 16'h0000) begin bad++; $display("[TB] FAIL seekwr_reg20_untouched got=%h exp=0000", ctrl_regs[20]); end
        write_word(16'h2020);
        total++; if (ctrl_regs[20] !== 16'h2020) begin bad++; $display("[TB] FAIL seekwr_reg20 got=%h exp=2020", ctrl_regs[20]); end
        total++; if (ctrl_wr_pulse !== 32'h0010_0000) begin bad++; $display("[TB] FAIL seekwr_pulse20 got=%h exp=00100000", ctrl_wr_pulse); end
    endtask

    task automatic test_seek_read();
        seek_ctrl(5'd5);
        write_word(16'h5A5A);
        write_word(16'h6B6B);
        bus.user_control_regs_16_addr        = 5'd5;
        bus.user_control_regs_16_addr_update = 1'b1;
        bus.user_r_control_regs_16_rden      = 1'b1;
        #1;
        total++; if (bus.user_r_control_regs_16_empty !== 1'b1) begin bad++; $display("[TB] FAIL rd_empty_c0 got=%b exp=1", bus.user_r_control_regs_16_empty); end
        @(negedge bus_clk);
        bus.user_control_regs_16_addr_update = 1'b0;
        #1;
        total++; if (bus.user_r_control_regs_16_empty !== 1'b1) begin bad++; $display("[TB] FAIL rd_empty_c1 got=%b exp=1", bus.user_r_control_regs_16_empty); end
        @(negedge bus_clk);
        total++; if (bus.user_r_control_regs_16_data !== 16'h0000) begin bad++; $display("[TB] FAIL rd_ignored got=%h exp=0000", bus.user_r_control_regs_16_data); end
        total++; if (bus.user_r_control_regs_16_empty !== 1'b0) begin bad++; $display("[TB] FAIL rd_empty_c2 got=%b exp=0", bus.user_r_control_regs_16_empty); end
        @(negedge bus_clk);
        total++; if (bus.user_r_control_regs_16_data !== 16'h5A5A) begin bad++; $display("[TB] FAIL rd_reg5 got=%h exp=5a5a", bus.user_r_control_regs_16_data); end
        @(negedge bus_clk);
        bus.user_r_control_regs_16_rden = 1'b0;
        total++; if (bus.user_r_control_regs_16_data !== 16'h6B6B) begin bad++; $display("[TB] FAIL rd_reg6 got=%h exp=6b6b", bus.user_r_control_regs_16_data); end
        @(negedge bus_clk);
        total++; if (bus.user_r_control_regs_16_data !== 16'h6B6B) begin bad++; $display("[TB] FAIL rd_hold got=%h exp=6b6b", bus.user_r_control_regs_16_data); end
    endtask

    task automatic test_self_clear();
        total++; if (ctrl_regs[7] !== 16'h0C0C) begin bad++; $display("[TB] FAIL sc_reg7_init got=%h exp=0c0c", ctrl_regs[7]); end
        seek_ctrl(5'd7);
        write_word(16'hFFFF);
        total++; if (ctrl_regs[7] !== 16'hFFFF) begin bad++; $display("[TB] FAIL sc_reg7_written got=%h exp=ffff", ctrl_regs[7]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0080) begin bad++; $display("[TB] FAIL sc_pulse7 got=%h exp=00000080", ctrl_wr_pulse); end
        @(negedge bus_clk);
        total++; if (ctrl_regs[7] !== 16'h0C0C) begin bad++; $display("[TB] FAIL sc_reg7_cleared got=%h exp=0c0c", ctrl_regs[7]); end
        total++; if (ctrl_regs[8] !== 16'h0000) begin bad++; $display("[TB] FAIL sc_reg8 got=%h exp=0000", ctrl_regs[8]); end
    endtask

    task automatic test_back_to_back();
        seek_ctrl(5'd2);
        @(negedge bus_clk);
        bus.user_w_control_regs_16_wren = 1'b1;
        bus.user_w_control_regs_16_data = 16'h7777;
        bus.user_r_control_regs_16_rden = 1'b1;
        @(negedge bus_clk);
        bus.user_w_control_regs_16_wren = 1'b0;
        bus.user_r_control_regs_16_rden = 1'b0;
        total++; if (bus.user_r_control_regs_16_data !== 16'h2222) begin bad++; $display("[TB] FAIL rw_old_value got=%h exp=2222", bus.user_r_control_regs_16_data); end
        total++; if (ctrl_regs[2] !== 16'h7777) begin bad++; $display("[TB] FAIL rw_reg2 got=%h exp=7777", ctrl_regs[2]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0004) begin bad++; $display("[TB] FAIL rw_pulse2 got=%h exp=00000004", ctrl_wr_pulse); end
        bus.user_r_control_regs_16_rden = 1'b1;
        @(negedge bus_clk);
        bus.user_r_control_regs_16_rden = 1'b0;
        total++; if (bus.user_r_control_regs_16_data !== 16'hA5A5) begin bad++; $display("[TB] FAIL rw_next_reg3 got=%h exp=a5a5", bus.user_r_control_regs_16_data); end
    endtask

    task automatic test_status();
        bus.user_status_regs_16_addr        = 5'd9;
        bus.user_status_regs_16_addr_update = 1'b1;
        bus.user_r_status_regs_16_rden      = 1'b1;
        #1;
        total++; if (bus.user_r_status_regs_16_empty !== 1'b1) begin bad++; $display("[TB] FAIL st_empty_c0 got=%b exp=1", bus.user_r_status_regs_16_empty); end
        total++; if (bus.user_r_control_regs_16_empty !== 1'b0) begin bad++; $display("[TB] FAIL st_ctrl_empty got=%b exp=0", bus.user_r_control_regs_16_empty); end
        @(negedge bus_clk);
        bus.user_status_regs_16_addr_update = 1'b0;
        bus.user_r_status_regs_16_rden      = 1'b0;
        #1;
        total++; if (bus.user_r_status_regs_16_empty !== 1'b1) begin bad++; $display("[TB] FAIL st_empty_c1 got=%b exp=1", bus.user_r_status_regs_16_empty); end
        @(negedge bus_clk);
        bus.user_r_status_regs_16_rden = 1'b1;
        @(negedge bus_clk);
        total++; if (bus.user_r_status_regs_16_data !== 16'hBEEF) begin bad++; $display("[TB] FAIL st_word9 got=%h exp=beef", bus.user_r_status_regs_16_data); end
        @(negedge bus_clk);
        bus.user_r_status_regs_16_rden = 1'b0;
        total++; if (bus.user_r_status_regs_16_data !== 16'hCAFE) begin bad++; $display("[TB] FAIL st_word10 got=%h exp=cafe", bus.user_r_status_regs_16_data); end
    endtask

    task automatic test_reset_override();
        reset = 1'b1;
        bus.user_w_control_regs_16_wren      = 1'b1;
        bus.user_w_control_regs_16_data      = 16'h1111;
        bus.user_r_control_regs_16_rden      = 1'b1;
        bus.user_r_status_regs_16_rden       = 1'b1;
        bus.user_control_regs_16_addr        = 5'd17;
        bus.user_control_regs_16_addr_update = 1'b1;
        @(negedge bus_clk);
        reset = 1'b0;
        idle();
        total++; if (ctrl_regs !== TB_RESET) begin bad++; $display("[TB] FAIL rst_ovr_regs got=%h exp=%h", ctrl_regs, TB_RESET); end
        total++; if (ctrl_wr_pulse !== 32'd0) begin bad++; $display("[TB] FAIL rst_ovr_pulse got=%h exp=0", ctrl_wr_pulse); end
        total++; if (bus.user_r_control_regs_16_data !== 16'd0) begin bad++; $display("[TB] FAIL rst_ovr_rdata got=%h exp=0", bus.user_r_control_regs_16_data); end
        total++; if (bus.user_r_status_regs_16_data !== 16'd0) begin bad++; $display("[TB] FAIL rst_ovr_sdata got=%h exp=0", bus.user_r_status_regs_16_data); end
        total++; if (bus.user_r_control_regs_16_empty !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovr_empty got=%b exp=0", bus.user_r_control_regs_16_empty); end
        @(negedge bus_clk);
        total++; if (ctrl_wr_pulse !== 32'd0) begin bad++; $display("[TB] FAIL rst_ovr_no_pulse got=%h exp=0", ctrl_wr_pulse); end
        write_word(16'h4242);
        total++; if (ctrl_regs[0] !== 16'h4242) begin bad++; $display("[TB] FAIL rst_cptr0 got=%h exp=4242", ctrl_regs[0]); end
        total++; if (ctrl_wr_pulse !== 32'h0000_0001) begin bad++; $display("[TB] FAIL rst_cptr0_pulse got=%h exp=00000001", ctrl_wr_pulse); end
        bus.user_r_status_regs_16_rden = 1'b1;
        @(negedge bus_clk);
        bus.user_r_status_regs_16_rden = 1'b0;
        total++; if (bus.user_r_status_regs_16_data !== 16'h0F0F) begin bad++; $display("[TB] FAIL rst_sptr0 got=%h exp=0f0f", bus.user_r_status_regs_16_data); end
    endtask

    initial begin
        reset     = 1'b1;
        status_in = '0;
        status_in[0]  = 16'h0F0F;
        status_in[9]  = 16'hBEEF;
        status_in[10] = 16'hCAFE;
        bus.user_w_control_regs_16_open = 1'b1;
        bus.user_r_control_regs_16_open = 1'b1;
        bus.user_r_status_regs_16_open  = 1'b1;
        idle();
        test_reset();
        test_write_seq();
        test_wrap();
        test_seek_read();
        test_self_clear();
        test_back_to_back();
        test_status();
        test_reset_override();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
